exa_crosb_input_vc_arbiter: RTL
===============================

# exa_crosb_input_vc_arbiter

Per-input-port VC selector that sits directly downstream of the crossbar ingress (e2s) stage, one instance per switch input. It picks one ready virtual channel (VC) from the port's per-priority/per-VC FIFOs, requests the target crossbar output, and holds the lock until the packet's last beat. It drives the select and clear-to-send (CTS) lines that dequeue the ingress FIFOs. Selection is strict priority between classes and round-robin within each class, gated by downstream credit availability.

## Interface
Parameters:
- `prio_num`, 2, number of priority classes.
- `vc_num`, 2, VCs per class. Total VC count V = prio_num*vc_num.
- `output_num`, 4, number of crossbar outputs.
- `logVcPrio`, log2(V), width of a VC index.
- `logOutput`, log2(output_num), width of a destination index.

Ports:
- `Clk` in 1: clock.
- `Reset` in 1: **synchronous, active-high** reset.
- `i_has_packet` in V: ingress FIFO non-empty, one bit per VC.
- `i_dests` in V x logOutput: head-of-FIFO destination output, per VC.
- `i_output_vc` in V x logVcPrio: head-of-FIFO output VC, per VC.
- `i_credit_avail` in output_num x V: downstream output VC has space for one max packet.
- `i_tvalid`, `i_tlast` in 1: selected-FIFO beat valid / last.
- `i_tready` in 1: crossbar accepts the beat.
- `o_req` in→out output_num: one-hot request to an output arbiter (direction: out).
- `i_gnt` in output_num: grant from the output arbiters.
- `o_selected_vc` out logVcPrio: VC index driven to the ingress mux.
- `o_cts` out 1: dequeue enable for the selected VC.
- `o_pkt_start` out 1: one-cycle pulse on the first accepted beat of a packet.
- `o_pkt_out_vc` out logVcPrio: output VC of the packet being sent; valid with `o_pkt_start`.
- `o_pkt_dest` out logOutput: destination of the packet being sent; valid with `o_pkt_start`.

## Operation
- Eligibility: `elig[v] = i_has_packet[v] & i_credit_avail[i_dests[v]][i_output_vc[v]]`.
- Class order: VC indices ≥ vc_num are high priority. If any high-class VC is eligible, choose among high-class VCs only.
- Within a class: round-robin. Each class has its own pointer `rr_ptr[p]`. Search starts at `rr_ptr[p]` and wraps modulo vc_num.
- State machine, three states:
  - **IDLE**: if any VC is eligible, register the winner into `sel_vc`, `sel_dest` and `sel_ovc`, then go to REQ. Otherwise stay in IDLE.
  - **REQ**: hold `o_req[sel_dest]=1`. On `i_gnt[sel_dest]`, go to XFER. There is no abort: the request is held until granted.
  - **XFER**:
    - `o_req[sel_dest]` stays high (the lock is held).
    - `o_cts = i_tready & i_tvalid`.
    - On `i_tvalid & i_tready & i_tlast`, go to IDLE and set `rr_ptr[class(sel_vc)] = (sel_vc mod vc_num)+1` with wrap.
- `o_selected_vc = sel_vc` in every state. It is stable from REQ through the last beat.
- `o_pkt_start` fires on the first XFER beat where `i_tvalid & i_tready`. A `first` flag is set on entry to XFER and cleared on that beat.
- Single-beat packet (tlast on the first beat): `o_pkt_start` and the return to IDLE happen in the same cycle.
- Credit deassertion during XFER is ignored; eligibility is checked at selection only.

## Timing
- Reset values:
  - State is IDLE.
  - `o_req`, `o_cts`, `o_pkt_start` are 0.
  - `o_selected_vc`, `o_pkt_out_vc`, `o_pkt_dest` are 0.
  - All `rr_ptr` are 0.
- Reset asserted mid-packet: the block returns to IDLE on the next edge and drops `o_req`. Upstream is reset together with this block.
- Latency:
  - Eligible → `o_req` high: 1 cycle.
  - `i_gnt` → earliest `o_cts`: 1 cycle, because the XFER state is registered.
  - Last beat → next `o_req`: 2 cycles (IDLE reselect, then REQ).
- `o_cts` is combinational from `i_tready`/`i_tvalid` in XFER and is never asserted outside XFER.
- A grant seen while in IDLE or XFER of a different dest is ignored.

## Structure
- The shared crossbar package holds:
  - an `arb_state_t` enum {IDLE, REQ, XFER};
  - a `vc_class(v)` function;
  - the rr-find helper.
- Natural sub-module: `exa_crosb_rr_pick`, parameterised (width N, one-hot request, pointer → one-hot grant, index). It is instantiated once per priority class.

## Test plan
1. Only VC1 (low) has a packet, credit available, 3 beats, tready=1 → `o_req` one cycle later, `o_cts` one cycle after the grant, three CTS beats, `o_pkt_start` on the first beat, then IDLE.
2. VC0 (low) and VC2 (high) both eligible → VC2 selected first; VC0 is served after VC2's tlast.
3. VC0 and VC1 both eligible with repeated packets → grants alternate 0,1,0,1.
4. VC3 has a packet but the credit for its (dest=2, ovc=3) is 0 → no `o_req`. Raising credit → `o_req[2]` on the next cycle.
5. Grant withheld 5 cycles, then `i_tready` toggles during XFER → `o_req` held, `o_selected_vc` stable, `o_cts` follows `i_tready`, no extra dequeues.
6. Reset asserted while in XFER → next cycle: state IDLE, all outputs 0, `rr_ptr` = 0.

Source files
------------

// File: rtl/exa_crosb_input_vc_arbiter_pkg.sv
// Shared crossbar definitions for the input VC arbiter: FSM states, the VC
// class helper and the round-robin search helper used by the pick sub-module.
package exa_crosb_input_vc_arbiter_pkg;

  localparam int RR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  function automatic int vc_class(input int v, input int vcs);
    return v / vcs;
  endfunction

  // Walks backwards so that the entry closest to ptr (in wrap order) is the
  // last one written; returns -1 when nothing is requesting.
  function automatic int rr_find(input logic [RR_MAX_W-1:0] req, input int ptr, input int n);
    int j;
    rr_find = -1;
    for (int k = n - 1; k >= 0; k--) begin
      j = (ptr + k) % n;
      if (req[j[4:0]]) rr_find = j;
    end
  endfunction

endpackage

// File: rtl/exa_crosb_rr_pick.sv
// Round-robin picker: starting at ptr_i, returns the first requester as a
// one-hot grant plus its index. Purely combinational.
module exa_crosb_rr_pick
  import exa_crosb_input_vc_arbiter_pkg::*;
#(
  parameter int N    = 2,
  parameter int PTRW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PTRW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PTRW-1:0] idx_o
);

  int hit;

  always_comb begin
    hit   = rr_find(RR_MAX_W'(req_i), int'(ptr_i), N);
    idx_o = '0;
    gnt_o = '0;
    if (hit >= 0) begin
      idx_o        = PTRW'(hit);
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/exa_crosb_input_vc_arbiter.sv
// Per-input-port VC selector: strict priority across classes, round-robin
// within a class, credit-gated; locks the crossbar output until the last beat.
module exa_crosb_input_vc_arbiter
  import exa_crosb_input_vc_arbiter_pkg::*;
#(
  parameter int prio_num   = 2,
  parameter int vc_num     = 2,
  parameter int output_num = 4,
  parameter int logVcPrio  = $clog2(prio_num * vc_num),
  parameter int logOutput  = $clog2(output_num)
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic [prio_num*vc_num-1:0]           i_has_packet,
  input  logic [prio_num*vc_num*logOutput-1:0] i_dests,
  input  logic [prio_num*vc_num*logVcPrio-1:0] i_output_vc,
  input  logic [output_num*prio_num*vc_num-1:0] i_credit_avail,
  input  logic                                 i_tvalid,
  input  logic                                 i_tlast,
  input  logic                                 i_tready,
  output logic [output_num-1:0]                o_req,
  input  logic [output_num-1:0]                i_gnt,
  output logic [logVcPrio-1:0]                 o_selected_vc,
  output logic                                 o_cts,
  output logic                                 o_pkt_start,
  output logic [logVcPrio-1:0]                 o_pkt_out_vc,
  output logic [logOutput-1:0]                 o_pkt_dest
);

  localparam int V    = prio_num * vc_num;
  localparam int PtrW = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int ClsW = (prio_num > 1) ? $clog2(prio_num) : 1;

  arb_state_t state_q, state_d;
  logic [logVcPrio-1:0] sel_vc_q, sel_vc_d;
  logic [logOutput-1:0] sel_dest_q, sel_dest_d;
  logic [logVcPrio-1:0] sel_ovc_q, sel_ovc_d;
  logic                 first_q, first_d;
  logic [prio_num-1:0][PtrW-1:0] rr_ptr_q, rr_ptr_d;

  logic [logOutput-1:0] dest_arr [V];
  logic [logVcPrio-1:0] ovc_arr  [V];
  logic [V-1:0]         elig;

  logic [prio_num-1:0][vc_num-1:0] cls_gnt;
  logic [prio_num-1:0][PtrW-1:0]   cls_idx;

  logic [prio_num:0]    any_chain;
  logic [logVcPrio-1:0] vc_chain [prio_num+1];
  logic                 win_any;
  logic [logVcPrio-1:0] win_vc;

  logic            beat;
  logic [ClsW-1:0] sel_cls;
  logic [PtrW-1:0] rr_next;

  // Credit is indexed by {destination, output VC} of each FIFO head.
  for (genvar v = 0; v < V; v++) begin : g_elig
    assign dest_arr[v] = i_dests[v*logOutput +: logOutput];
    assign ovc_arr[v]  = i_output_vc[v*logVcPrio +: logVcPrio];
    assign elig[v]     = i_has_packet[v] & i_credit_avail[{dest_arr[v], ovc_arr[v]}];
  end

  for (genvar p = 0; p < prio_num; p++) begin : g_cls
    exa_crosb_rr_pick #(
      .N   (vc_num),
      .PTRW(PtrW)
    ) u_pick (
      .req_i(elig[p*vc_num +: vc_num]),
      .ptr_i(rr_ptr_q[p]),
      .gnt_o(cls_gnt[p]),
      .idx_o(cls_idx[p])
    );
  end

  // Higher class numbers sit later in the chain and override lower ones.
  assign any_chain[0] = 1'b0;
  assign vc_chain[0]  = '0;
  for (genvar p = 0; p < prio_num; p++) begin : g_prio
    assign any_chain[p+1] = any_chain[p] | (|cls_gnt[p]);
    assign vc_chain[p+1]  = (|cls_gnt[p]) ? logVcPrio'(p * vc_num) + logVcPrio'(cls_idx[p])
                                          : vc_chain[p];
  end
  assign win_any = any_chain[prio_num];
  assign win_vc  = vc_chain[prio_num];

  assign beat    = i_tvalid & i_tready;
  assign sel_cls = ClsW'(vc_class(int'(sel_vc_q), vc_num));
  assign rr_next = PtrW'((int'(sel_vc_q) % vc_num + 1) % vc_num);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      sel_vc_q   <= '0;
      sel_dest_q <= '0;
      sel_ovc_q  <= '0;
      first_q    <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_vc_q   <= sel_vc_d;
      sel_dest_q <= sel_dest_d;
      sel_ovc_q  <= sel_ovc_d;
      first_q    <= first_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_vc_d    = sel_vc_q;
    sel_dest_d  = sel_dest_q;
    sel_ovc_d   = sel_ovc_q;
    first_d     = first_q;
    rr_ptr_d    = rr_ptr_q;
    o_req       = '0;
    o_cts       = 1'b0;
    o_pkt_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          sel_vc_d   = win_vc;
          sel_dest_d = dest_arr[win_vc];
          sel_ovc_d  = ovc_arr[win_vc];
          state_d    = REQ;
        end
      end
      REQ: begin
        o_req[sel_dest_q] = 1'b1;
        if (i_gnt[sel_dest_q]) begin
          state_d = XFER;
          first_d = 1'b1;
        end
      end
      XFER: begin
        // The output lock is held for the whole packet, stalls included.
        o_req[sel_dest_q] = 1'b1;
        o_cts             = beat;
        if (beat) begin
          o_pkt_start = first_q;
          first_d     = 1'b0;
          if (i_tlast) begin
            state_d           = IDLE;
            rr_ptr_d[sel_cls] = rr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_selected_vc = sel_vc_q;
  assign o_pkt_out_vc  = sel_ovc_q;
  assign o_pkt_dest    = sel_dest_q;

endmodule
